alu_share_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters, e.g. the execute stage (requester 0) and the branch/address unit (requester 1).
- Each request is a valid/ready transaction carrying two operands and a 4-bit opcode.
- Round-robin arbitration, one issue per cycle, two-stage registered pipeline (operand register, result register).
- Results return on a shared response bus tagged with the requester ID.

---
 rtl/alu_share_arbiter.sv | 89 ++++++++
 tb/tb_alu_share_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters via a two-stage registered pipeline
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy
);
  logic              gnt0, gnt1;
  logic              ptr_q, ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_id_q, s1_id_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  always_comb begin
    gnt0 = !reset && !hold && req0_valid && (!req1_valid || !ptr_q);
    gnt1 = !reset && !hold && req1_valid && (!req0_valid || ptr_q);
    ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
    s1_valid_d = gnt0 || gnt1;
    s1_id_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : s1_id_q;
    d1_d = gnt0 ? req0_a : gnt1 ? req1_a : d1_q;
    d2_d = gnt0 ? req0_b : gnt1 ? req1_b : d2_q;
    op_d = gnt0 ? req0_op : gnt1 ? req1_op : op_q;
    rsp_valid_d = s1_valid_q;
    rsp_id_d = s1_valid_q ? s1_id_q : rsp_id_q;
    rsp_result_d = s1_valid_q ? alu_result : rsp_result_q;
    rsp_zero_d = s1_valid_q ? alu_zero : rsp_zero_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
      op_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q <= s1_id_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_data1 = d1_q;
  assign alu_data2 = d2_q;
  assign alu_op = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero = rsp_zero_q;
  assign busy = s1_valid_q || rsp_valid_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with an accept-time scoreboard and a response monitor
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic reset, hold;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [31:0] alu_data1, alu_data2, alu_result, rsp_result;
  logic alu_zero, rsp_valid, rsp_id, rsp_zero, busy;
  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] exp0, exp1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );
  always_comb begin
    alu_result = alu_data1 + alu_data2;
    case (alu_op)
      4'b0001: alu_result = alu_data1 - alu_data2;
      4'b0010: alu_result = alu_data1 & alu_data2;
      4'b0011: alu_result = alu_data1 | alu_data2;
      4'b0100: alu_result = alu_data1 ^ alu_data2;
      default: alu_result = alu_data1 + alu_data2;
    endcase
    alu_zero = (alu_result == 32'd0);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual id=%0d result=%h required=no response at %0t", rsp_id, rsp_result, $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
      end
    end
    if (reset) sb.delete();
    else begin
      if (req0_ready) sb.push_back('{1'b0, exp0, exp0 == 32'd0});
      if (req1_ready) sb.push_back('{1'b1, exp1, exp1 == 32'd0});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic outs_zero(input string tag);
    chk({tag, "_alu_data1"}, 64'(alu_data1), 64'd0);
    chk({tag, "_alu_data2"}, 64'(alu_data2), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask
  initial begin
    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    exp0 = '0; exp1 = '0;
    step();
    req0_valid = 1'b1;
    @(negedge clk);
    chk("ready0_in_reset", 64'(req0_ready), 64'd0);
    step();
    reset = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    outs_zero("idle");
    chk("idle_ready0", 64'(req0_ready), 64'd0);
    chk("idle_ready1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0001; exp0 = 32'd2;
    @(negedge clk);
    chk("single_ready0", 64'(req0_ready), 64'd1);
    chk("single_ready1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_alu_op", 64'(alu_op), 64'h1);
    chk("single_alu_data1", 64'(alu_data1), 64'd5);
    chk("single_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("single_rsp_pulse", 64'(rsp_valid), 64'd0);
    step();
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 4'b0010; exp1 = 32'h0F;
    @(negedge clk);
    chk("solo1_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    repeat (3) step();
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 4'b0000; exp0 = 32'd0;
    req1_valid = 1'b1; req1_a = 32'hA5A5_A5A5; req1_b = 32'hA5A5_A5A5; req1_op = 4'b0100; exp1 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("contend_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      chk("contend_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      step();
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready0", 64'(req0_ready), 64'd0);
      chk("hold_ready1", 64'(req1_ready), 64'd0);
      if (i == 0) chk("hold_busy", 64'(busy), 64'd1);
      if (i == 1) chk("hold_inflight_rsp", 64'(rsp_valid), 64'd1);
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("after_hold_ready1", 64'(req1_ready), 64'd1);
    chk("after_hold_ready0", 64'(req0_ready), 64'd0);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("after_hold2_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0011; exp1 = 32'hFF;
    @(negedge clk);
    chk("flush_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("flush_ready_in_reset", 64'(req1_ready), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    outs_zero("flush");
    repeat (2) step();
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8; req0_op = 4'b1111; exp0 = 32'd15;
    @(negedge clk);
    chk("op15_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("op15_alu_op", 64'(alu_op), 64'hF);
    @(negedge clk);
    chk("op15_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("op15_rsp_result", 64'(rsp_result), 64'd15);
    @(negedge clk);
    chk("op15_rsp_pulse", 64'(rsp_valid), 64'd0);
    repeat (2) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
